// File: rtl/add_round_key_ks.sv
// AES round-key stage: expands the next round key one word per cycle
// through a single shared 4-byte S-box and XORs it into the state.
module add_round_key_ks #(
   parameter int word_size  = 8,
   parameter int array_size = 16
) (
   input  logic                              clk,
   input  logic                              rst,
   input  logic                              enable,
   input  logic [word_size*array_size-1:0]   state,
   input  logic [word_size*array_size-1:0]   key_in,
   input  logic [3:0]                        round,
   output logic [word_size*array_size-1:0]   state_out,
   output logic [word_size*array_size-1:0]   key_out,
   output logic                              done
);

   localparam int W = word_size * array_size;

   localparam logic [7:0] SBOX [256] = '{
      8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5,
      8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
      8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0,
      8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
      8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc,
      8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
      8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a,
      8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
      8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0,
      8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
      8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b,
      8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
      8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85,
      8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
      8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5,
      8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
      8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17,
      8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
      8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88,
      8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
      8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c,
      8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
      8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9,
      8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
      8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6,
      8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
      8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e,
      8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
      8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94,
      8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
      8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68,
      8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
   };

   typedef enum logic [1:0] {IDLE, EXPAND, FIN} fsm_t;

   fsm_t          cur, nxt;
   logic [1:0]    cnt;
   logic [W-1:0]  st_q, key_q, fin_key;
   logic [3:0]    rnd_q;
   logic [31:0]   nw [4];
   logic [31:0]   kw [4];
   logic [31:0]   rot, sub, prev, word;
   logic [7:0]    rcon;

   always_comb begin
      kw[0] = key_q[127:96];
      kw[1] = key_q[95:64];
      kw[2] = key_q[63:32];
      kw[3] = key_q[31:0];
   end

   always_comb begin
      case (rnd_q)
         4'd1:    rcon = 8'h01;
         4'd2:    rcon = 8'h02;
         4'd3:    rcon = 8'h04;
         4'd4:    rcon = 8'h08;
         4'd5:    rcon = 8'h10;
         4'd6:    rcon = 8'h20;
         4'd7:    rcon = 8'h40;
         4'd8:    rcon = 8'h80;
         4'd9:    rcon = 8'h1b;
         4'd10:   rcon = 8'h36;
         default: rcon = 8'h00;
      endcase
   end

   // The single shared S-box only matters on cnt=0; later words chain on nw.
   always_comb begin
      rot  = {kw[3][23:0], kw[3][31:24]};
      sub  = {SBOX[rot[31:24]], SBOX[rot[23:16]],
              SBOX[rot[15:8]],  SBOX[rot[7:0]]};
      prev = (cnt == 2'd0) ? (sub ^ {rcon, 24'h0})
                           : nw[cnt - 2'd1];
      word = kw[cnt] ^ prev;
      fin_key = (rnd_q == 4'd0) ? key_q
                                : {nw[0], nw[1], nw[2], nw[3]};
   end

   always_comb begin
      nxt = cur;
      case (cur)
         IDLE:    if (enable) nxt = (round == 4'd0) ? FIN : EXPAND;
         EXPAND:  if (cnt == 2'd3) nxt = FIN;
         FIN:     nxt = IDLE;
         default: nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         cur       <= IDLE;
         cnt       <= 2'd0;
         st_q      <= '0;
         key_q     <= '0;
         rnd_q     <= 4'd0;
         state_out <= '0;
         key_out   <= '0;
         done      <= 1'b0;
         for (int i = 0; i < 4; i++) nw[i] <= 32'h0;
      end else begin
         cur  <= nxt;
         done <= 1'b0;
         case (cur)
            IDLE: begin
               if (enable) begin
                  st_q  <= state;
                  key_q <= key_in;
                  rnd_q <= round;
                  cnt   <= 2'd0;
               end
            end
            EXPAND: begin
               nw[cnt] <= word;
               cnt     <= cnt + 2'd1;
            end
            FIN: begin
               key_out   <= fin_key;
               state_out <= st_q ^ fin_key;
               done      <= 1'b1;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_add_round_key_ks.sv
// Bench for add_round_key_ks: directed AES vectors plus random traffic
// compared every cycle against a cycle-count behavioural model.
module tb_add_round_key_ks;

   logic         clk = 1'b0;
   logic         rst;
   logic         enable;
   logic [127:0] state, key_in;
   logic [3:0]   round;
   logic [127:0] state_out, key_out;
   logic         done;

   int tests = 0;
   int fails = 0;

   add_round_key_ks #(.word_size(8), .array_size(16)) dut (
      .clk(clk), .rst(rst), .enable(enable), .state(state),
      .key_in(key_in), .round(round), .state_out(state_out),
      .key_out(key_out), .done(done)
   );

   always #5 clk = ~clk;

   logic [7:0] sb [256];

   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p = 8'h0;
      for (int i = 0; i < 8; i++) begin
         if (b[0]) p = p ^ a;
         a = a[7] ? ((a << 1) ^ 8'h1b) : (a << 1);
         b = b >> 1;
      end
      return p;
   endfunction

   function automatic logic [7:0] rotl(input logic [7:0] x, input int n);
      return (x << n) | (x >> (8 - n));
   endfunction

   // S-box derived from GF(2^8) inverse plus affine map.
   task automatic build_sbox();
      logic [7:0] inv;
      for (int x = 0; x < 256; x++) begin
         inv = 8'h0;
         for (int y = 1; y < 256; y++)
            if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
         sb[x] = inv ^ rotl(inv, 1) ^ rotl(inv, 2) ^ rotl(inv, 3)
                 ^ rotl(inv, 4) ^ 8'h63;
      end
   endtask

   function automatic logic [127:0] expand(input logic [127:0] k, input logic [3:0] r);
      logic [31:0] w [4];
      logic [31:0] t;
      logic [7:0]  rc;
      if (r == 4'd0) return k;
      for (int i = 0; i < 4; i++) w[i] = k[127 - 32*i -: 32];
      if (r <= 4'd8) rc = 8'h01 << (r - 4'd1);
      else if (r == 4'd9) rc = 8'h1b;
      else if (r == 4'd10) rc = 8'h36;
      else rc = 8'h00;
      t = {w[3][23:0], w[3][31:24]};
      t = {sb[t[31:24]], sb[t[23:16]], sb[t[15:8]], sb[t[7:0]]};
      t = t ^ {rc, 24'h0};
      w[0] = w[0] ^ t;
      for (int i = 1; i < 4; i++) w[i] = w[i] ^ w[i-1];
      return {w[0], w[1], w[2], w[3]};
   endfunction

   function automatic void chk(input string nm, input logic [127:0] act,
                               input logic [127:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endfunction

   // Behavioural model: remaining cycles until done, outputs from spec rules.
   int           remain = 0;
   bit           started = 0;
   logic [127:0] cap_s, cap_k, exp_so = '0, exp_ko = '0;
   logic [3:0]   cap_r;
   logic         exp_done = 1'b0;

   always @(posedge clk) begin
      started  <= 1'b1;
      exp_done = 1'b0;
      if (!rst) begin
         remain = 0;
         exp_so = '0;
         exp_ko = '0;
      end else if (remain == 0) begin
         if (enable) begin
            cap_s  = state;
            cap_k  = key_in;
            cap_r  = round;
            remain = (round == 4'd0) ? 1 : 5;
         end
      end else begin
         remain--;
         if (remain == 0) begin
            exp_ko   = expand(cap_k, cap_r);
            exp_so   = cap_s ^ exp_ko;
            exp_done = 1'b1;
         end
      end
   end

   always @(negedge clk) begin
      if (started) begin
         chk("cyc_done", {127'h0, done}, {127'h0, exp_done});
         chk("cyc_key", key_out, exp_ko);
         chk("cyc_state", state_out, exp_so);
      end
   end

   localparam logic [127:0] K0 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
   localparam logic [127:0] K1 = 128'ha0fafe1788542cb123a339392a6c7605;

   task automatic start_op(input logic [127:0] s, input logic [127:0] k,
                           input logic [3:0] r, output int n);
      state  = s;
      key_in = k;
      round  = r;
      enable = 1'b1;
      @(negedge clk);
      enable = 1'b0;
      n = 1;
      while (!done && n < 20) begin
         @(negedge clk);
         n++;
      end
      if (!done) chk("timeout", 128'h0, 128'h1);
   endtask

   task automatic wait_done(output int n);
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!done && n < 20);
      if (!done) chk("timeout", 128'h0, 128'h1);
   endtask

   initial begin
      int n, nd;
      logic [127:0] seen_k, seen_s;
      rst = 1'b0; enable = 1'b1;
      state = '0; key_in = '0; round = 4'd0;
      build_sbox();

      chk("sbox_00", {120'h0, sb[0]}, 128'h63);
      chk("sbox_53", {120'h0, sb[8'h53]}, 128'hed);
      chk("model_r1", expand(K0, 4'd1), K1);
      chk("model_r10", expand(128'hac7766f319fadc2128d12941575c006e, 4'd10),
          128'hd014f9a8c9ee2589e13f0cc8b6630ca6);

      // Reset held with enable high
      @(negedge clk);
      @(negedge clk);
      chk("rst_so", state_out, 128'h0);
      chk("rst_ko", key_out, 128'h0);
      chk("rst_done", {127'h0, done}, 128'h0);
      rst = 1'b1; enable = 1'b0;
      @(negedge clk);

      start_op(128'h3243f6a8885a308d313198a2e0370734, K0, 4'd0, n);
      chk("r0_lat", 128'(n), 128'd2);
      chk("r0_so", state_out, 128'h193de3bea0f4e22b9ac68d2ae9f84808);
      chk("r0_ko", key_out, K0);
      @(negedge clk);
      chk("r0_pulse", {127'h0, done}, 128'h0);

      start_op(128'h046681e5e0cb199a48f8d37a2806264c, K0, 4'd1, n);
      chk("r1_lat", 128'(n), 128'd6);
      chk("r1_ko", key_out, K1);
      chk("r1_so", state_out, 128'ha49c7ff2689f352b6b5bea43026a5049);
      @(negedge clk);

      start_op($urandom, 128'hac7766f319fadc2128d12941575c006e, 4'd10, n);
      chk("r10_ko", key_out, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
      @(negedge clk);

      // Busy: extra enable and input changes during EXPAND
      state = 128'h046681e5e0cb199a48f8d37a2806264c;
      key_in = K0; round = 4'd1; enable = 1'b1;
      @(negedge clk);
      enable = 1'b0;
      state = {$urandom, $urandom, $urandom, $urandom};
      key_in = {$urandom, $urandom, $urandom, $urandom};
      @(negedge clk);
      enable = 1'b1; round = 4'd0;
      @(negedge clk);
      enable = 1'b0;
      nd = 0; seen_k = '0; seen_s = '0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (done) begin
            nd++;
            seen_k = key_out;
            seen_s = state_out;
         end
      end
      chk("busy_ndone", 128'(nd), 128'd1);
      chk("busy_ko", seen_k, K1);
      chk("busy_so", seen_s, 128'ha49c7ff2689f352b6b5bea43026a5049);

      // Reset while cnt=2
      state = {$urandom, $urandom, $urandom, $urandom};
      key_in = K0; round = 4'd1; enable = 1'b1;
      @(negedge clk);
      enable = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      chk("mid_so", state_out, 128'h0);
      chk("mid_ko", key_out, 128'h0);
      chk("mid_done", {127'h0, done}, 128'h0);
      rst = 1'b1;
      nd = 0;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         if (done) nd++;
      end
      chk("mid_nodone", 128'(nd), 128'd0);

      // Back-to-back with key feedback
      state = {$urandom, $urandom, $urandom, $urandom};
      key_in = K0; round = 4'd1; enable = 1'b1;
      wait_done(n);
      chk("b2b_lat1", 128'(n), 128'd6);
      chk("b2b_ko1", key_out, K1);
      key_in = key_out; round = 4'd2;
      wait_done(n);
      chk("b2b_gap", 128'(n), 128'd6);
      chk("b2b_ko2", key_out, 128'hf2c295f27a96b9435935807a7359f67f);
      enable = 1'b0;
      @(negedge clk);

      // Random traffic checked every cycle by the model
      for (int i = 0; i < 500; i++) begin
         rst    = ($urandom_range(0, 49) != 0);
         enable = ($urandom_range(0, 2) != 0);
         state  = {$urandom, $urandom, $urandom, $urandom};
         key_in = {$urandom, $urandom, $urandom, $urandom};
         round  = 4'($urandom_range(0, 15));
         @(negedge clk);
      end
      rst = 1'b1; enable = 1'b0;
      repeat (8) @(negedge clk);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
